// File: rtl/mix_pkg.sv
// rtl/mix_pkg.sv - shared MIX word widths, divide-controller states and timing constants
package mix_pkg;

    localparam int MIX_W = 31;
    localparam int MAG_W = 30;
    localparam int DIV_CAPT_CYCLE = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DIVS  = 3'd2,
        ST_RUN   = 3'd3,
        ST_CAPT  = 3'd4,
        ST_DONE  = 3'd5
    } div_state_e;

endpackage

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - sequences one MIX DIV through the shared divider and forms rA/rX results
module div_ctrl
    import mix_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [MIX_W-1:0]  a_in,
    input  logic [MIX_W-1:0]  x_in,
    input  logic [MIX_W-1:0]  v_in,
    output logic              busy,
    output logic              done,
    output logic [MIX_W-1:0]  a_out,
    output logic [MIX_W-1:0]  x_out,
    output logic              ovf_set,
    output logic              stop_err,
    output logic              div_start,
    output logic [60:0]       div_dividend,
    output logic [MIX_W-1:0]  div_divisor,
    input  logic              div_stop,
    input  logic              div_sign,
    input  logic              div_overflow,
    input  logic [MAG_W-1:0]  div_quotient,
    input  logic [MAG_W-1:0]  div_rest
);

    div_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [MIX_W-1:0] a_lat_q, a_lat_d;
    logic [MIX_W-1:0] x_lat_q, x_lat_d;
    logic [MIX_W-1:0] v_lat_q, v_lat_d;
    logic [MAG_W-1:0] quo_q, quo_d;
    logic [MAG_W-1:0] rest_q, rest_d;
    logic             sign_q, sign_d;
    logic             dovf_q, dovf_d;
    logic [MIX_W-1:0] a_out_q, a_out_d;
    logic [MIX_W-1:0] x_out_q, x_out_d;

    logic             in_done;
    logic             take_ovf;
    logic [MIX_W-1:0] a_res;
    logic [MIX_W-1:0] x_res;

    // A missing stop from the divider is treated exactly like an overflow.
    assign in_done  = (state_q == ST_DONE);
    assign take_ovf = dovf_q | ~div_stop;
    assign a_res    = take_ovf ? a_lat_q : {sign_q, quo_q};
    assign x_res    = take_ovf ? x_lat_q : {a_lat_q[MIX_W-1], rest_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_lat_d = a_lat_q;
        x_lat_d = x_lat_q;
        v_lat_d = v_lat_q;
        quo_d   = quo_q;
        rest_d  = rest_q;
        sign_d  = sign_q;
        dovf_d  = dovf_q;
        a_out_d = a_out_q;
        x_out_d = x_out_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                if (req) begin
                    a_lat_d = a_in;
                    x_lat_d = x_in;
                    v_lat_d = v_in;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = cnt_q + 4'd1;
                state_d = ST_DIVS;
            end
            ST_DIVS: begin
                cnt_d   = cnt_q + 4'd1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // cnt_q tracks the T-index, so the last RUN cycle is one before capture.
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(DIV_CAPT_CYCLE - 1)) begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                cnt_d   = cnt_q + 4'd1;
                quo_d   = div_quotient;
                rest_d  = div_rest;
                sign_d  = div_sign;
                dovf_d  = div_overflow;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                cnt_d   = 4'd0;
                a_out_d = a_res;
                x_out_d = x_res;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            a_lat_q <= '0;
            x_lat_q <= '0;
            v_lat_q <= '0;
            quo_q   <= '0;
            rest_q  <= '0;
            sign_q  <= 1'b0;
            dovf_q  <= 1'b0;
            a_out_q <= '0;
            x_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_lat_q <= a_lat_d;
            x_lat_q <= x_lat_d;
            v_lat_q <= v_lat_d;
            quo_q   <= quo_d;
            rest_q  <= rest_d;
            sign_q  <= sign_d;
            dovf_q  <= dovf_d;
            a_out_q <= a_out_d;
            x_out_q <= x_out_d;
        end
    end

    // Results show up in the DONE cycle itself and are held in a_out_q/x_out_q afterwards.
    assign a_out        = in_done ? a_res : a_out_q;
    assign x_out        = in_done ? x_res : x_out_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = in_done;
    assign ovf_set      = in_done & take_ovf;
    assign stop_err     = in_done & ~div_stop;
    assign div_start    = (state_q == ST_START);
    assign div_dividend = div_start ? {a_lat_q[MIX_W-1], a_lat_q[MAG_W-1:0], x_lat_q[MAG_W-1:0]} : '0;
    assign div_divisor  = (busy && !in_done) ? v_lat_q : '0;

endmodule
